// File: rtl/sh7034_pkg.sv
// rtl/sh7034_pkg.sv - shared constants for SH7034 subsystem peers
package sh7034_pkg;

  // Byte shifted out when the SCI clocks a byte and the TX FIFO has nothing queued.
  localparam logic [7:0] SCI_PEER_IDLE_BYTE = 8'hFF;

endpackage

// File: rtl/sci_sync_peer_if.sv
// rtl/sci_sync_peer_if.sv - device-side byte handshake of the SCI sync peer
interface sci_sync_peer_if;
  logic [7:0] TX_DATA;
  logic       TX_WR;
  logic       TX_FULL;
  logic       TX_EMPTY;
  logic [7:0] RX_DATA;
  logic       RX_VALID;

  modport master (
    output TX_DATA, TX_WR,
    input  TX_FULL, TX_EMPTY, RX_DATA, RX_VALID
  );

  modport slave (
    input  TX_DATA, TX_WR,
    output TX_FULL, TX_EMPTY, RX_DATA, RX_VALID
  );
endinterface

// File: rtl/sci_peer_fifo.sv
// rtl/sci_peer_fifo.sv - show-ahead synchronous FIFO with registered exact flags
module sci_peer_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int WIDTH      = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CE,
  input  logic             WR,
  input  logic [WIDTH-1:0] WDATA,
  input  logic             RD,
  output logic [WIDTH-1:0] RDATA,
  output logic             FULL,
  output logic             EMPTY
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0] wp_q, wp_d, rp_q, rp_d;
  logic        full_q, full_d, empty_q, empty_d;
  logic        wr_en, rd_en;

  assign wr_en = WR & ~full_q;
  assign rd_en = RD & ~empty_q;

  // Flags come from the next pointers so they are exact in the cycle after any update.
  always_comb begin
    wp_d    = wr_en ? wp_q + PTR_ONE : wp_q;
    rp_d    = rd_en ? rp_q + PTR_ONE : rp_q;
    empty_d = (wp_d == rp_d);
    full_d  = (wp_d[AW] != rp_d[AW]) && (wp_d[AW-1:0] == rp_d[AW-1:0]);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wp_q    <= '0;
      rp_q    <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else if (CE) begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (CE && wr_en) mem[wp_q[AW-1:0]] <= WDATA;
  end

  assign RDATA = mem[rp_q[AW-1:0]];
  assign FULL  = full_q;
  assign EMPTY = empty_q;
endmodule

// File: rtl/sci_sync_peer.sv
// rtl/sci_sync_peer.sv - device-side endpoint of the SH7034 SCI clocked-synchronous mode
module sci_sync_peer
  import sh7034_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic CE,
  input  logic EN,
  input  logic SCK_I,
  input  logic SDI,
  output logic SDO,
  output logic TX_UNDERRUN,
  output logic SYNC_ERR,
  sci_sync_peer_if.slave bus
);
  localparam logic [15:0] IDLE_LIMIT = 16'(IDLE_TIMEOUT);

  logic       sck_s1_q, sck_s2_q, sck_prev_q;
  logic       sck_fall, sck_rise;
  logic [2:0] bcnt_q, bcnt_d;
  logic [7:0] tsr_q, tsr_d, rsr_q, rsr_d, rx_data_q, rx_data_d;
  logic       sdo_q, sdo_d;
  logic       rx_valid_q, rx_valid_d, underrun_q, underrun_d, sync_err_q, sync_err_d;
  logic [15:0] idle_q, idle_d;
  logic       fifo_rd, fifo_empty, fifo_full;
  logic [7:0] fifo_rdata;

  sci_peer_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .CLK   (CLK),
    .RST_N (RST_N),
    .CE    (CE),
    .WR    (bus.TX_WR),
    .WDATA (bus.TX_DATA),
    .RD    (fifo_rd),
    .RDATA (fifo_rdata),
    .FULL  (fifo_full),
    .EMPTY (fifo_empty)
  );

  assign sck_fall = sck_prev_q & ~sck_s2_q;
  assign sck_rise = ~sck_prev_q & sck_s2_q;

  always_comb begin
    bcnt_d     = bcnt_q;
    tsr_d      = tsr_q;
    rsr_d      = rsr_q;
    rx_data_d  = rx_data_q;
    sdo_d      = sdo_q;
    idle_d     = idle_q;
    rx_valid_d = 1'b0;
    underrun_d = 1'b0;
    sync_err_d = 1'b0;
    fifo_rd    = 1'b0;

    if (!EN) begin
      bcnt_d = 3'd0;
      sdo_d  = 1'b1;
      idle_d = 16'd0;
    end else if (sck_fall) begin
      idle_d = 16'd0;
      if (bcnt_q == 3'd0) begin
        if (!fifo_empty) begin
          fifo_rd = 1'b1;
          tsr_d   = fifo_rdata;
          sdo_d   = fifo_rdata[0];
        end else begin
          tsr_d      = SCI_PEER_IDLE_BYTE;
          sdo_d      = 1'b1;
          underrun_d = 1'b1;
        end
      end else begin
        sdo_d = tsr_q[bcnt_q];
      end
    end else if (sck_rise) begin
      idle_d = 16'd0;
      rsr_d  = {SDI, rsr_q[7:1]};
      bcnt_d = bcnt_q + 3'd1;
      if (bcnt_q == 3'd7) begin
        rx_data_d  = {SDI, rsr_q[7:1]};
        rx_valid_d = 1'b1;
      end
    end else if (idle_q == IDLE_LIMIT) begin
      // Saturated timer: clearing BCNT makes the abandon (and SYNC_ERR) happen only once.
      sdo_d = 1'b1;
      if (bcnt_q != 3'd0) begin
        bcnt_d     = 3'd0;
        rsr_d      = 8'd0;
        sync_err_d = 1'b1;
      end
    end else begin
      idle_d = idle_q + 16'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sck_s1_q   <= 1'b1;
      sck_s2_q   <= 1'b1;
      sck_prev_q <= 1'b1;
      bcnt_q     <= 3'd0;
      tsr_q      <= 8'd0;
      rsr_q      <= 8'd0;
      rx_data_q  <= 8'd0;
      sdo_q      <= 1'b1;
      idle_q     <= 16'd0;
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
      sync_err_q <= 1'b0;
    end else if (CE) begin
      sck_s1_q   <= SCK_I;
      sck_s2_q   <= sck_s1_q;
      sck_prev_q <= sck_s2_q;
      bcnt_q     <= bcnt_d;
      tsr_q      <= tsr_d;
      rsr_q      <= rsr_d;
      rx_data_q  <= rx_data_d;
      sdo_q      <= sdo_d;
      idle_q     <= idle_d;
      rx_valid_q <= rx_valid_d;
      underrun_q <= underrun_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign SDO          = sdo_q;
  assign TX_UNDERRUN  = underrun_q;
  assign SYNC_ERR     = sync_err_q;
  assign bus.RX_DATA  = rx_data_q;
  assign bus.RX_VALID = rx_valid_q;
  assign bus.TX_FULL  = fifo_full;
  assign bus.TX_EMPTY = fifo_empty;
endmodule
